pwm_duty_meter: RTL

PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_duty_div.sv | 75 +++++++
 rtl/pwm_duty_meter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, FSM state type and helpers for the PWM meter and generator
package pwm_pkg;

   localparam int DUTY_W          = 10;
   localparam int CNT_W           = 20;
   localparam int DUTY_SCALE_LOG2 = 10;
   localparam int DIVIDEND_W      = CNT_W + DUTY_SCALE_LOG2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } pwm_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// rtl/pwm_duty_div.sv - restoring divider, one quotient bit per cycle, DUTY_SCALE_LOG2 iterations
module pwm_duty_div
   import pwm_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  abort,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [CNT_W-1:0]      divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DUTY_W-1:0]     quotient
);

   localparam logic [3:0] LAST_ITER = 4'(DUTY_SCALE_LOG2 - 1);

   logic [CNT_W-1:0]           rem_q;
   logic [CNT_W-1:0]           dvsr_q;
   logic [DUTY_SCALE_LOG2-1:0] low_q;
   logic [DUTY_W-1:0]          quo_q;
   logic [3:0]                 iter_q;
   logic                       busy_q;
   logic                       done_q;

   logic [CNT_W:0]   rem_shift;
   logic [CNT_W:0]   rem_diff;
   logic [CNT_W-1:0] rem_nxt;
   logic             ge;

   // The upper dividend bits are below the divisor, so only the low bits need shifting in.
   always_comb begin
      rem_shift = {rem_q, low_q[DUTY_SCALE_LOG2-1]};
      ge        = (rem_shift >= {1'b0, dvsr_q});
      rem_diff  = rem_shift - {1'b0, dvsr_q};
      rem_nxt   = ge ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q  <= '0;
         dvsr_q <= '0;
         low_q  <= '0;
         quo_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            busy_q <= 1'b0;
         end else if (start && !busy_q) begin
            rem_q  <= dividend[DIVIDEND_W-1:DUTY_SCALE_LOG2];
            low_q  <= dividend[DUTY_SCALE_LOG2-1:0];
            dvsr_q <= divisor;
            iter_q <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q  <= rem_nxt;
            low_q  <= {low_q[DUTY_SCALE_LOG2-2:0], 1'b0};
            quo_q  <= {quo_q[DUTY_W-2:0], ge};
            iter_q <= iter_q + 1'b1;
            if (iter_q == LAST_ITER) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - PWM period, high time and duty measurement with stuck-input timeout
module pwm_duty_meter
   import pwm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty_cycle,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              timeout,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_dly_q;
   logic                   s;
   logic                   rise;
   logic                   fall;
   logic                   any_edge;

   pwm_state_e        state_q;
   logic [CNT_W-1:0]  hcnt_q;
   logic [CNT_W-1:0]  lcnt_q;
   logic [CNT_W-1:0]  idle_cnt_q;
   logic [CNT_W-1:0]  idle_cnt_d;
   logic [CNT_W-1:0]  cap_p_q;
   logic [CNT_W-1:0]  cap_h_q;
   logic [DUTY_W-1:0] duty_q;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  high_q;
   logic              valid_q;
   logic              timeout_q;
   logic              overrun_q;

   logic [CNT_W:0]      p_sum;
   logic [CNT_W-1:0]    p_cap;
   logic                timeout_fire;
   logic                capture;
   logic                div_start;
   logic                div_busy;
   logic                div_done;
   logic [DUTY_W-1:0]   div_quotient;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_dly_q <= s;
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign rise     = s & ~s_dly_q;
   assign fall     = ~s & s_dly_q;
   assign any_edge = rise | fall;

   // Counter parks at the limit so the timeout fires once per stuck episode.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (any_edge) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != TIMEOUT_LIM) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   assign timeout_fire = !any_edge && (idle_cnt_q == TIMEOUT_LIM - 1'b1);

   // Sum saturates like the counters; only reachable with timeouts near full scale.
   assign p_sum     = {1'b0, hcnt_q} + {1'b0, lcnt_q};
   assign p_cap     = p_sum[CNT_W] ? CNT_MAX : p_sum[CNT_W-1:0];
   assign capture   = (state_q == ST_LOW) && rise;
   assign div_start = capture && !div_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         hcnt_q     <= '0;
         lcnt_q     <= '0;
         idle_cnt_q <= '0;
         cap_p_q    <= '0;
         cap_h_q    <= '0;
         duty_q     <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         idle_cnt_q <= idle_cnt_d;
         if (any_edge) begin
            timeout_q <= 1'b0;
         end
         if (timeout_fire) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
            duty_q    <= s ? {DUTY_W{1'b1}} : '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b1;
         end else begin
            if (div_done) begin
               duty_q   <= div_quotient;
               period_q <= cap_p_q;
               high_q   <= cap_h_q;
               valid_q  <= 1'b1;
            end
            unique case (state_q)
               ST_IDLE: begin
                  if (rise) begin
                     hcnt_q  <= CNT_W'(1);
                     state_q <= ST_HIGH;
                  end
               end
               ST_HIGH: begin
                  if (fall) begin
                     lcnt_q  <= CNT_W'(1);
                     state_q <= ST_LOW;
                  end else begin
                     hcnt_q <= sat_inc(hcnt_q);
                  end
               end
               ST_LOW: begin
                  if (rise) begin
                     if (div_busy) begin
                        overrun_q <= 1'b1;
                     end else begin
                        cap_p_q <= p_cap;
                        cap_h_q <= hcnt_q;
                     end
                     hcnt_q  <= CNT_W'(1);
                     state_q <= ST_HIGH;
                  end else begin
                     lcnt_q <= sat_inc(lcnt_q);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   pwm_duty_div u_div (
      .clk      (clk),
      .reset    (reset),
      .abort    (timeout_fire),
      .start    (div_start),
      .dividend ({hcnt_q, {DUTY_SCALE_LOG2{1'b0}}}),
      .divisor  (p_cap),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   assign duty_cycle = duty_q;
   assign period     = period_q;
   assign high_time  = high_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;
   assign overrun    = overrun_q;

endmodule
